// File: rtl/life_pkg.sv
// life_pkg
// Shared types for the 16x16 Game of Life datapath. The pattern-entry stage
// and the generation stepper both use these grid types.
//   GRID_N        : grid edge length in cells
//   row_t         : one row, bit x = column x, 1 = alive
//   grid_t        : full grid indexed [y][x]
//   life_state_e  : stepper FSM states
//   next_cell()   : Conway rule for one cell given its neighbour count
package life_pkg;

  localparam int GRID_N = 16;

  typedef logic [GRID_N-1:0] row_t;
  typedef row_t [GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2
  } life_state_e;

  // Birth on exactly three neighbours, survival on two or three.
  function automatic logic next_cell(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// life_engine_if
// Bundles the control/data signals between the pattern-entry/control side
// and the generation stepper.
//   load    : pulse, capture pattern into the live grid
//   pattern : initial grid [y][x]
//   run     : level, stepping enabled
//   tick    : single-cycle step strobe
//   cells   : live grid shown on the display
//   gen     : generations since last load, saturating
//   busy    : step in progress
//   stable  : last committed step left the grid unchanged
//   extinct : live grid is empty
// master = controller side, slave = stepper side.
interface life_engine_if #(
  parameter int GEN_W = 10
);
  import life_pkg::*;

  logic             load;
  grid_t            pattern;
  logic             run;
  logic             tick;
  grid_t            cells;
  logic [GEN_W-1:0] gen;
  logic             busy;
  logic             stable;
  logic             extinct;

  modport master (
    output load, pattern, run, tick,
    input  cells, gen, busy, stable, extinct
  );

  modport slave (
    input  load, pattern, run, tick,
    output cells, gen, busy, stable, extinct
  );

endinterface

// File: rtl/life_row.sv
// life_row
// Combinational next-generation for one grid row.
//   above   : row y-1 (all zero when y is the top row)
//   cur     : row y
//   below   : row y+1 (all zero when y is the bottom row)
//   nxt_row : row y of the next generation
// Columns beyond x=0 and x=15 are dead; the rows are padded with a zero on
// each side so every column sees a three-wide window.
module life_row
  import life_pkg::*;
(
  input  row_t above,
  input  row_t cur,
  input  row_t below,
  output row_t nxt_row
);

  logic [GRID_N+1:0] pad_above;
  logic [GRID_N+1:0] pad_cur;
  logic [GRID_N+1:0] pad_below;

  assign pad_above = {1'b0, above, 1'b0};
  assign pad_cur   = {1'b0, cur,   1'b0};
  assign pad_below = {1'b0, below, 1'b0};

  // Padded index x+1 is column x, so x, x+1, x+2 span the neighbourhood.
  function automatic logic [3:0] nbr_count(
    input logic [2:0] a,
    input logic [1:0] c,
    input logic [2:0] b
  );
    return 4'(a[0]) + 4'(a[1]) + 4'(a[2]) +
           4'(c[0]) + 4'(c[1]) +
           4'(b[0]) + 4'(b[1]) + 4'(b[2]);
  endfunction

  always_comb begin
    nxt_row = '0;
    for (int x = 0; x < GRID_N; x++) begin
      nxt_row[x] = next_cell(cur[x],
                             nbr_count(pad_above[x +: 3],
                                       {pad_cur[x+2], pad_cur[x]},
                                       pad_below[x +: 3]));
    end
  end

endmodule

// File: rtl/life_engine.sv
// life_engine
// Game of Life generation stepper. Captures a pattern on load, then on each
// accepted tick builds the next generation one row per cycle into a shadow
// buffer and commits it to the live grid in a single edge.
//   clk   : system clock
//   reset : asynchronous, active-high; clears all state
//   bus   : life_engine_if slave (load/pattern/run/tick in,
//           cells/gen/busy/stable/extinct out)
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting; load captures pattern, run&tick starts a step
// ST_COMPUTE | row counter walks 0..15 writing the shadow buffer
// ST_COMMIT  | shadow buffer becomes the live grid, gen/stable updated
module life_engine
  import life_pkg::*;
#(
  parameter int GEN_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  life_engine_if.slave  bus
);

  life_state_e      state;
  logic [3:0]       row;
  grid_t            cells_q;
  grid_t            nxt;
  logic [GEN_W-1:0] gen_q;
  logic             stable_q;

  row_t above;
  row_t cur;
  row_t below;
  row_t next_row;

  // Neighbouring rows outside the grid are dead; no wrap-around.
  always_comb begin
    cur   = cells_q[row];
    above = (row == 4'd0)             ? '0 : cells_q[row - 4'd1];
    below = (row == 4'(GRID_N - 1))   ? '0 : cells_q[row + 4'd1];
  end

  life_row u_life_row (
    .above   (above),
    .cur     (cur),
    .below   (below),
    .nxt_row (next_row)
  );

  // The live grid is only read while computing and only written on commit or
  // load, so the display never shows a half-updated generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      cells_q  <= '0;
      nxt      <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else if (bus.load) begin
      // Load wins everywhere; a step in flight is abandoned.
      cells_q  <= bus.pattern;
      gen_q    <= '0;
      stable_q <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.run && bus.tick) begin
            row   <= '0;
            state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          nxt[row] <= next_row;
          row      <= row + 4'd1;
          if (row == 4'(GRID_N - 1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          stable_q <= (nxt == cells_q);
          cells_q  <= nxt;
          if (gen_q != '1) begin
            gen_q <= gen_q + GEN_W'(1);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cells   = cells_q;
  assign bus.gen     = gen_q;
  assign bus.stable  = stable_q;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.extinct = (cells_q == '0);

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine
// Directed Game of Life patterns followed by randomized load/run/tick traffic.
// Expected results come from a cell-by-cell neighbour-counting model and are
// queued at the moment a load or step is accepted; a monitor pops them when
// the engine presents a result (load captured or busy falling).
module tb_life_engine;
  import life_pkg::*;

  logic clk;
  logic reset;

  life_engine_if #(.GEN_W(10)) bus ();
  life_engine_if #(.GEN_W(2))  bus2 ();

  life_engine #(.GEN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  life_engine #(.GEN_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.load    = bus.load;
  assign bus2.pattern = bus.pattern;
  assign bus2.run     = bus.run;
  assign bus2.tick    = bus.tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    grid_t cells;
    int    steps;
    logic  stable;
    logic  extinct;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: the grid as it will be once the accepted step commits.
  grid_t m_cells;
  int    m_steps;
  logic  m_stable;
  int    busy_left;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic grid_t model_next(input grid_t g);
    grid_t r;
    r = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dy == 0 && dx == 0) && (y + dy) >= 0 && (y + dy) < 16 &&
                (x + dx) >= 0 && (x + dx) < 16) begin
              n += int'(g[y+dy][x+dx]);
            end
          end
        end
        r[y][x] = (n == 3) || (g[y][x] && n == 2);
      end
    end
    return r;
  endfunction

  function automatic logic is_empty(input grid_t g);
    int live;
    live = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        live += int'(g[y][x]);
    return (live == 0);
  endfunction

  function automatic grid_t rand_grid();
    grid_t g;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        g[y][x] = ($urandom_range(0, 2) == 0);
    return g;
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.cells   = m_cells;
    e.steps   = m_steps;
    e.stable  = m_stable;
    e.extinct = is_empty(m_cells);
    return e;
  endfunction

  // Drive one cycle of inputs (called at posedge+1), then account for what the
  // engine does with them at the next edge.
  task automatic step(input logic ld, input grid_t pat, input logic rn, input logic tk);
    logic busy_now;
    bus.load    = ld;
    bus.pattern = pat;
    bus.run     = rn;
    bus.tick    = tk;
    @(posedge clk);
    busy_now = (busy_left != 0);
    if (ld) begin
      if (busy_now && q.size() != 0) void'(q.pop_back());
      m_cells   = pat;
      m_steps   = 0;
      m_stable  = 1'b0;
      busy_left = 0;
      q.push_back(mk_exp());
    end else if (!busy_now && rn && tk) begin
      grid_t nx;
      nx        = model_next(m_cells);
      m_stable  = (nx == m_cells);
      m_cells   = nx;
      m_steps++;
      busy_left = 17;
      q.push_back(mk_exp());
    end else if (busy_now) begin
      busy_left--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic load_grid(input grid_t g);
    step(1'b1, g, 1'b1, 1'b0);
  endtask

  task automatic tick_and_wait();
    step(1'b0, '0, 1'b1, 1'b1);
    idle(18);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cells"},   bus.cells,   '0);
    chk({tag, "_gen"},     bus.gen,     '0);
    chk({tag, "_busy"},    bus.busy,    '0);
    chk({tag, "_stable"},  bus.stable,  '0);
    chk({tag, "_extinct"}, bus.extinct, 256'd1);
  endtask

  // Monitor: result presented when a load was captured or busy drops.
  logic load_seen;
  logic busy_prev;

  always @(posedge clk) load_seen <= reset ? 1'b0 : bus.load;

  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
    end else begin
      chk("busy", bus.busy, 256'(busy_left != 0));
      if (load_seen || (busy_prev && !bus.busy)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got gen %0d with no expected entry", bus.gen);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cells",   bus.cells,   e.cells);
          chk("gen",     bus.gen,     256'((e.steps > 1023) ? 1023 : e.steps));
          chk("gen_w2",  bus2.gen,    256'((e.steps > 3) ? 3 : e.steps));
          chk("stable",  bus.stable,  256'(e.stable));
          chk("extinct", bus.extinct, 256'(e.extinct));
        end
      end
      busy_prev = bus.busy;
    end
  end

  initial begin
    grid_t g;
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.pattern = '0;
    bus.run     = 1'b0;
    bus.tick    = 1'b0;
    m_cells     = '0;
    m_steps     = 0;
    m_stable    = 1'b0;
    busy_left   = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // Blinker: two steps return to the start.
    g = '0; g[7][6] = 1'b1; g[7][7] = 1'b1; g[7][8] = 1'b1;
    load_grid(g);
    tick_and_wait();
    tick_and_wait();

    // Tick with run low is dropped.
    step(1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // Block in the corner is a still life; extra ticks while busy are ignored.
    g = '0; g[0][0] = 1'b1; g[0][1] = 1'b1; g[1][0] = 1'b1; g[1][1] = 1'b1;
    load_grid(g);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(4);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(18);

    // Single cell dies, then the empty grid is stable.
    g = '0; g[5][5] = 1'b1;
    load_grid(g);
    tick_and_wait();
    tick_and_wait();
    tick_and_wait();

    // Glider heading into the bottom-right corner must not wrap.
    g = '0;
    g[12][13] = 1'b1; g[13][14] = 1'b1;
    g[14][12] = 1'b1; g[14][13] = 1'b1; g[14][14] = 1'b1;
    load_grid(g);
    for (int i = 0; i < 7; i++) begin
      tick_and_wait();
      chk("glider_row0", bus.cells[0], '0);
      for (int y = 0; y < 16; y++) begin
        g = bus.cells;
        if (g[y][0] !== 1'b0) chk("glider_col0", 256'(g[y][0]), '0);
      end
    end

    // Load and tick together in idle: load only.
    step(1'b1, rand_grid(), 1'b1, 1'b1);
    idle(3);

    // Load while computing row 8 aborts the step.
    load_grid(rand_grid());
    step(1'b0, '0, 1'b1, 1'b1);
    idle(8);
    load_grid(rand_grid());
    idle(3);

    // Reset mid-step: outputs clear without a clock edge.
    load_grid(rand_grid());
    step(1'b0, '0, 1'b1, 1'b1);
    idle(5);
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    q.delete();
    busy_left = 0;
    m_cells   = '0;
    m_steps   = 0;
    m_stable  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      load_grid(rand_grid());
      for (int c = 0; c < 60; c++) begin
        logic ld, rn, tk;
        ld = ($urandom_range(0, 49) == 0);
        rn = ($urandom_range(0, 3) != 0);
        tk = ($urandom_range(0, 3) == 0);
        step(ld, rand_grid(), rn, tk);
      end
    end

    idle(20);
    chk("queue_drained", 256'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
